// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory image loader: state encoding
// and the length-field and word widths.
package imem_loader_pkg;

    localparam int LEN_W  = 16;
    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CHECK,
        DONE,
        ERR
    } state_e;

endpackage

// File: rtl/imem_loader.sv
// Receives a length-prefixed, XOR-checksummed byte stream and writes it word
// by word into instruction memory while holding the CPU pipeline.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [31:0]       wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    state_e             state_q,   state_d;
    logic [LEN_W-1:0]   len_q,     len_d;
    logic [LEN_W-1:0]   idx_q,     idx_d;
    logic [1:0]         cnt_q,     cnt_d;
    logic [7:0]         xor_q,     xor_d;
    logic [WORD_W-1:0]  asm_q,     asm_d;
    logic               wr_en_q,   wr_en_d;
    logic [31:0]        wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0]  wr_data_q, wr_data_d;
    logic [LEN_W-1:0]   len_n;
    logic               xfer;

    assign xfer = byte_valid && byte_ready;

    // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        xor_d      = xor_q;
        asm_d      = asm_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        len_n      = {len_q[LEN_W-1:8], byte_data};
        byte_ready = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                     (state_q == DATA)   || (state_q == CHECK);

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = LEN_HI;
                    len_d   = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    xor_d   = '0;
                end
            end
            LEN_HI: begin
                if (xfer) begin
                    len_d   = {byte_data, 8'h00};
                    xor_d   = xor_q ^ byte_data;
                    state_d = LEN_LO;
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    len_d = len_n;
                    xor_d = xor_q ^ byte_data;
                    if (32'(len_n) > MAX_WORDS)
                        state_d = ERR;
                    else if (len_n == '0)
                        state_d = CHECK;
                    else
                        state_d = DATA;
                end
            end
            DATA: begin
                if (xfer) begin
                    asm_d = {asm_q[WORD_W-9:0], byte_data};
                    xor_d = xor_q ^ byte_data;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        // Address arithmetic is 32-bit and wraps naturally.
                        wr_en_d   = 1'b1;
                        wr_data_d = asm_d;
                        wr_addr_d = BASE_ADDR + {14'b0, idx_q, 2'b00};
                        idx_d     = idx_q + 16'd1;
                        if (idx_q + 16'd1 == len_q)
                            state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (xfer)
                    state_d = (byte_data == xor_q) ? DONE : ERR;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            len_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            xor_q     <= '0;
            asm_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            xor_q     <= xor_d;
            asm_q     <= asm_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign cpu_hold = (state_q != DONE);
    assign done     = (state_q == DONE);
    assign error    = (state_q == ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: valid, bad-checksum, oversize, empty,
// stalled and reset-aborted images.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];

    // Two-word image body: length 2, words 0x20080005 and 0x01095020.
    logic [7:0] img [0:9];
    // XOR of the ten body bytes: 02 ^ 2D ^ 78 = 0x57.
    logic [7:0] good_ck = 8'h57;

    imem_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
        end
    end

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!byte_ready) begin
            errors++;
            $display("FAIL send_byte_timeout byte=%02h ready=%0b expected ready=1", b, byte_ready);
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_image(input logic [7:0] ck, input bit gaps);
        for (int i = 0; i < 10; i++) begin
            if (gaps) begin
                repeat ((i * 7) % 4) @(negedge clk);
                if (i == 5) do_start();
            end
            send_byte(img[i]);
        end
        if (gaps) repeat (2) @(negedge clk);
        send_byte(ck);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_two_writes(input string tag);
        checks++;
        if (wa_q.size() !== 2) begin
            errors++;
            $display("FAIL %s_write_count got %0d expected 2", tag, wa_q.size());
        end else begin
            checks++;
            if (wa_q[0] !== 32'h0 || wd_q[0] !== 32'h2008_0005) begin
                errors++;
                $display("FAIL %s_word0 got %08h@%08h expected 20080005@00000000", tag, wd_q[0], wa_q[0]);
            end
            checks++;
            if (wa_q[1] !== 32'h4 || wd_q[1] !== 32'h0109_5020) begin
                errors++;
                $display("FAIL %s_word1 got %08h@%08h expected 01095020@00000004", tag, wd_q[1], wa_q[1]);
            end
        end
    endtask

    task automatic check_flags(input string tag, input logic e_done, input logic e_err,
                               input logic e_hold, input logic e_ready);
        checks++;
        if ({done, error, cpu_hold, byte_ready} !== {e_done, e_err, e_hold, e_ready}) begin
            errors++;
            $display("FAIL %s_flags got done=%0b error=%0b hold=%0b ready=%0b expected %0b %0b %0b %0b",
                     tag, done, error, cpu_hold, byte_ready, e_done, e_err, e_hold, e_ready);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (wr_en !== 1'b0 || wr_addr !== 32'h0 || wr_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_write_port got en=%0b addr=%08h data=%08h expected 0 0 0", wr_en, wr_addr, wr_data);
        end
        check_flags("reset", 1'b0, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_flags("idle_wait", 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_good_image();
        wa_q.delete(); wd_q.delete();
        do_start();
        check_flags("len_hi", 1'b0, 1'b0, 1'b1, 1'b1);
        send_image(good_ck, 1'b0);
        check_two_writes("good");
        check_flags("good", 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_bad_checksum();
        wa_q.delete(); wd_q.delete();
        do_start();
        send_image(8'h00, 1'b0);
        check_two_writes("badck");
        check_flags("badck", 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_too_long();
        wa_q.delete(); wd_q.delete();
        do_start();
        send_byte(8'h01);
        send_byte(8'h01);
        check_flags("too_long", 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (wa_q.size() !== 0) begin
            errors++;
            $display("FAIL too_long_writes got %0d expected 0", wa_q.size());
        end
    endtask

    task automatic test_empty_image();
        wa_q.delete(); wd_q.delete();
        do_start();
        send_byte(8'h00);
        send_byte(8'h00);
        check_flags("empty_check", 1'b0, 1'b0, 1'b1, 1'b1);
        send_byte(8'h00);
        repeat (2) @(negedge clk);
        check_flags("empty", 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (wa_q.size() !== 0) begin
            errors++;
            $display("FAIL empty_writes got %0d expected 0", wa_q.size());
        end
    endtask

    task automatic test_gaps();
        wa_q.delete(); wd_q.delete();
        do_start();
        send_image(good_ck, 1'b1);
        check_two_writes("gaps");
        check_flags("gaps", 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_abort();
        wa_q.delete(); wd_q.delete();
        do_start();
        for (int i = 0; i < 4; i++) send_byte(img[i]);
        rst_n = 1'b0;
        #1;
        checks++;
        if (wr_en !== 1'b0 || cpu_hold !== 1'b1 || byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_in_reset got en=%0b hold=%0b ready=%0b expected 0 1 0", wr_en, cpu_hold, byte_ready);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_flags("abort_idle", 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (wa_q.size() !== 0) begin
            errors++;
            $display("FAIL abort_writes got %0d expected 0", wa_q.size());
        end
        wa_q.delete(); wd_q.delete();
        do_start();
        send_image(good_ck, 1'b0);
        check_two_writes("after_abort");
        check_flags("after_abort", 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        img[0] = 8'h00; img[1] = 8'h02;
        img[2] = 8'h20; img[3] = 8'h08; img[4] = 8'h00; img[5] = 8'h05;
        img[6] = 8'h01; img[7] = 8'h09; img[8] = 8'h50; img[9] = 8'h20;
        test_reset();
        test_good_image();
        test_bad_checksum();
        test_too_long();
        test_empty_image();
        test_gaps();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout reached expected completion");
        $fatal(1, "timeout");
    end

endmodule
